// File: rtl/axi_cdc_isolate_ctrl.sv
// rtl/axi_cdc_isolate_ctrl.sv - dst-side AXI CDC isolation sequencer (block, drain, isolate, ack)
// Optional drain timeout: define AXI_CDC_ISO_TIMEOUT_EN.
module axi_cdc_isolate_ctrl #(
  parameter int MaxTxns       = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic dst_clk_i,
  input  logic dst_rst_ni,
  input  logic isolate_req_i,
  input  logic aw_hs_i,
  input  logic w_last_hs_i,
  input  logic b_hs_i,
  input  logic ar_hs_i,
  input  logic r_last_hs_i,
  output logic block_aw_o,
  output logic block_ar_o,
  output logic isolate_o,
  output logic isolated_o,
  output logic err_o,
  output logic timeout_o
);

  localparam int CntW = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0]      CntMax = CntW'(MaxTxns);
  localparam logic signed [CntW:0] BalMax = (CntW + 1)'(MaxTxns);
  localparam logic signed [CntW:0] BalMin = -BalMax;
  localparam logic signed [CntW:0] BalOne = (CntW + 1)'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic signed [CntW:0] w_bal_q, w_bal_d;
  logic                 wr_err, rd_err, bal_err, proto_err;
  logic                 drained;
  logic                 block_aw_q, block_ar_q, iso_q, err_q;

  // Write outstanding: AW opens, B closes; simultaneous events cancel.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_err   = 1'b0;
    if (aw_hs_i && !b_hs_i) begin
      if (wr_cnt_q == CntMax) wr_err = 1'b1;
      else                    wr_cnt_d = wr_cnt_q + 1'b1;
    end else if (b_hs_i && !aw_hs_i) begin
      if (wr_cnt_q == '0) wr_err = 1'b1;
      else                wr_cnt_d = wr_cnt_q - 1'b1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_err   = 1'b0;
    if (ar_hs_i && !r_last_hs_i) begin
      if (rd_cnt_q == CntMax) rd_err = 1'b1;
      else                    rd_cnt_d = rd_cnt_q + 1'b1;
    end else if (r_last_hs_i && !ar_hs_i) begin
      if (rd_cnt_q == '0) rd_err = 1'b1;
      else                rd_cnt_d = rd_cnt_q - 1'b1;
    end
  end

  // W may lead AW, so the balance is signed and saturates symmetrically.
  always_comb begin
    w_bal_d = w_bal_q;
    bal_err = 1'b0;
    if (aw_hs_i && !w_last_hs_i) begin
      if (w_bal_q == BalMax) bal_err = 1'b1;
      else                   w_bal_d = w_bal_q + BalOne;
    end else if (w_last_hs_i && !aw_hs_i) begin
      if (w_bal_q == BalMin) bal_err = 1'b1;
      else                   w_bal_d = w_bal_q - BalOne;
    end
  end

  assign proto_err = (state_q == ISOLATED) && (aw_hs_i || ar_hs_i);
  assign drained   = (wr_cnt_d == '0) && (rd_cnt_d == '0) && (w_bal_d == '0);

`ifdef AXI_CDC_ISO_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_hit, tmo_q;

  assign tmo_hit = (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (isolate_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_req_i)  state_d = RUN;
        else if (drained)    state_d = ISOLATED;
`ifdef AXI_CDC_ISO_TIMEOUT_EN
        else if (tmo_hit)    state_d = ISOLATED;
`endif
      end
      ISOLATED: if (!isolate_req_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Outputs follow the next state so they change in the same edge as the state.
  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      state_q    <= RUN;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      w_bal_q    <= '0;
      err_q      <= 1'b0;
      block_aw_q <= 1'b0;
      block_ar_q <= 1'b0;
      iso_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      w_bal_q    <= w_bal_d;
      err_q      <= err_q | wr_err | rd_err | bal_err | proto_err;
      block_aw_q <= (state_d != RUN) || (wr_cnt_d == CntMax);
      block_ar_q <= (state_d != RUN) || (rd_cnt_d == CntMax);
      iso_q      <= (state_d == ISOLATED);
    end
  end

`ifdef AXI_CDC_ISO_TIMEOUT_EN
  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (state_q == DRAIN) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                  tmo_cnt_q <= '0;
      if (state_q == RUN && state_d == DRAIN)
        tmo_q <= 1'b0;
      else if (state_q == DRAIN && state_d == ISOLATED && !drained)
        tmo_q <= 1'b1;
    end
  end

  assign timeout_o = tmo_q;
`else
  // Tied low; the parameter is still referenced so it elaborates in every build.
  assign timeout_o = 1'b0 & (TimeoutCycles > 0);
`endif

  assign block_aw_o = block_aw_q;
  assign block_ar_o = block_ar_q;
  assign isolate_o  = iso_q;
  assign isolated_o = iso_q;
  assign err_o      = err_q;

endmodule
